// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg : shared constants, FSM encoding and window ordering helpers
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cnn_pkg;

  localparam int TAPS          = 9;
  localparam int TAP_BIAS      = 9;
  localparam int TAPS_PER_FILT = 10;
  localparam int WIN_DIM       = 3;
  localparam int FMAP_DIM      = 26;
  localparam int FMAP_SIZE     = FMAP_DIM * FMAP_DIM;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_BIAS  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // Window taps arrive row-major: tap = row*WIN_DIM + col.
  function automatic int tap_row(input int tap);
    return tap / WIN_DIM;
  endfunction

  function automatic int tap_col(input int tap);
    return tap % WIN_DIM;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_conv_wbank.sv
// ----------------------------------------------------------------------------
// cnn_conv_wbank : NUM_FILT x 10 weight/bias register file, parallel read
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cnn_conv_wbank #(
  parameter int NUM_FILT = 4,
  parameter int W_WIDTH  = 8,
  parameter int ADDR_W   = $clog2(NUM_FILT * cnn_pkg::TAPS_PER_FILT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic                          w_we,
  input  logic [ADDR_W-1:0]             w_addr,
  input  logic [W_WIDTH-1:0]            w_data,
  input  logic [3:0]                    tap,
  output logic [NUM_FILT*W_WIDTH-1:0]   tap_w,
  output logic [NUM_FILT*W_WIDTH-1:0]   bias_w
);
  import cnn_pkg::*;

  localparam int DEPTH = NUM_FILT * TAPS_PER_FILT;

  logic [W_WIDTH-1:0] bank [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (w_we && wr_en && (w_addr < ADDR_W'(DEPTH))) begin
      bank[w_addr] <= w_data;
    end
  end

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_rd
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(f * TAPS_PER_FILT);
    assign tap_w[f*W_WIDTH +: W_WIDTH]  = bank[BASE + ADDR_W'(tap)];
    assign bias_w[f*W_WIDTH +: W_WIDTH] = bank[BASE + ADDR_W'(TAP_BIAS)];
  end

endmodule

`default_nettype wire

// File: rtl/cnn_conv3x3.sv
// ----------------------------------------------------------------------------
// cnn_conv3x3 : bit-serial 3x3 binary-window convolution, NUM_FILT in parallel
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cnn_conv3x3 #(
  parameter int NUM_FILT  = 4,
  parameter int W_WIDTH   = 8,
  parameter int ACC_WIDTH = 12,
  parameter int FMAP_SIZE = cnn_pkg::FMAP_SIZE,
  parameter int ADDR_W    = $clog2(NUM_FILT * cnn_pkg::TAPS_PER_FILT),
  parameter int FILT_W    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               strt,
  input  logic               din,
  output logic               bsy,
  input  logic               w_we,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic [W_WIDTH-1:0] w_data,
  output logic               fm_we,
  output logic [9:0]         fm_addr,
  output logic [FILT_W-1:0]  fm_filt,
  output logic [7:0]         fm_data,
  output logic               frame_done
);
  import cnn_pkg::*;

  localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILT - 1);
  localparam logic [9:0]        LAST_PIX  = 10'(FMAP_SIZE - 1);
  localparam logic [3:0]        LAST_TAP  = 4'(TAPS - 1);

  state_t                      state;
  logic [3:0]                  tap;
  logic [FILT_W-1:0]           fcnt;
  logic [FILT_W-1:0]           next_filt;
  logic [9:0]                  pix;
  logic signed [ACC_WIDTH-1:0] acc      [NUM_FILT];
  logic signed [ACC_WIDTH-1:0] tap_ext  [NUM_FILT];
  logic signed [ACC_WIDTH-1:0] biased   [NUM_FILT];
  logic [NUM_FILT*W_WIDTH-1:0] tap_w;
  logic [NUM_FILT*W_WIDTH-1:0] bias_w;

  cnn_conv_wbank #(
    .NUM_FILT (NUM_FILT),
    .W_WIDTH  (W_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_wbank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (state == ST_IDLE),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .tap    (tap),
    .tap_w  (tap_w),
    .bias_w (bias_w)
  );

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    logic [W_WIDTH-1:0] wv;
    logic [W_WIDTH-1:0] bv;
    assign wv         = tap_w[f*W_WIDTH +: W_WIDTH];
    assign bv         = bias_w[f*W_WIDTH +: W_WIDTH];
    assign tap_ext[f] = {{(ACC_WIDTH-W_WIDTH){wv[W_WIDTH-1]}}, wv};
    assign biased[f]  = acc[f] + {{(ACC_WIDTH-W_WIDTH){bv[W_WIDTH-1]}}, bv};
  end

  assign next_filt = fcnt + 1'b1;
  assign bsy       = (state != ST_IDLE);

  function automatic logic [7:0] relu_sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v[ACC_WIDTH-1])
      return 8'd0;
    else if (|v[ACC_WIDTH-2:8])
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  // The first write is loaded on the BIAS edge from the biased sum so that
  // registered fm_* outputs line up with the WRITE cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tap        <= '0;
      fcnt       <= '0;
      pix        <= '0;
      fm_we      <= 1'b0;
      fm_addr    <= '0;
      fm_filt    <= '0;
      fm_data    <= '0;
      frame_done <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) acc[f] <= '0;
    end else if (clr) begin
      state      <= ST_IDLE;
      tap        <= '0;
      fcnt       <= '0;
      pix        <= '0;
      fm_we      <= 1'b0;
      frame_done <= 1'b0;
      for (int f = 0; f < NUM_FILT; f++) acc[f] <= '0;
    end else begin
      fm_we      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (strt) begin
            state <= ST_SHIFT;
            tap   <= '0;
            for (int f = 0; f < NUM_FILT; f++) acc[f] <= '0;
          end
        end
        ST_SHIFT: begin
          if (din) begin
            for (int f = 0; f < NUM_FILT; f++) acc[f] <= acc[f] + tap_ext[f];
          end
          if (tap == LAST_TAP) state <= ST_BIAS;
          else                 tap   <= tap + 4'd1;
        end
        ST_BIAS: begin
          for (int f = 0; f < NUM_FILT; f++) acc[f] <= biased[f];
          state   <= ST_WRITE;
          fcnt    <= '0;
          fm_we   <= 1'b1;
          fm_filt <= '0;
          fm_addr <= pix;
          fm_data <= relu_sat(biased[0]);
        end
        default: begin
          if (fcnt == LAST_FILT) begin
            state <= ST_IDLE;
            if (pix == LAST_PIX) begin
              pix        <= '0;
              frame_done <= 1'b1;
            end else begin
              pix <= pix + 10'd1;
            end
          end else begin
            fcnt    <= next_filt;
            fm_we   <= 1'b1;
            fm_filt <= next_filt;
            fm_addr <= pix;
            fm_data <= relu_sat(acc[next_filt]);
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnn_conv3x3.sv
// ----------------------------------------------------------------------------
// tb_cnn_conv3x3 : scoreboard bench for cnn_conv3x3
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cnn_conv3x3;

  localparam int NF     = 4;
  localparam int FW     = 2;
  localparam int AW     = 6;
  localparam int FMAP   = 676;
  localparam int WR_END = 10 + NF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, strt, din, w_we;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data;
  logic          bsy, fm_we, frame_done;
  logic [9:0]    fm_addr;
  logic [FW-1:0] fm_filt;
  logic [7:0]    fm_data;

  always #5 clk = ~clk;

  cnn_conv3x3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .strt       (strt),
    .din        (din),
    .bsy        (bsy),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .fm_we      (fm_we),
    .fm_addr    (fm_addr),
    .fm_filt    (fm_filt),
    .fm_data    (fm_data),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [9:0]    addr;
    logic [FW-1:0] filt;
    logic [7:0]    data;
  } wr_t;

  wr_t sb[$];
  int  n_vec  = 0;
  int  n_err  = 0;
  int  frames = 0;
  int  tb_pix = 0;
  int  m_w [NF][10];
  bit  mon_en = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (frame_done) frames++;
      if (fm_we) begin
        if (sb.size() == 0) begin
          check("fm_unexpected", 1, 0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("fm_addr", fm_addr, e.addr);
          check("fm_filt", fm_filt, e.filt);
          check("fm_data", fm_data, e.data);
        end
      end
    end
  end

  function automatic logic [7:0] model(input int f, input logic [8:0] bits);
    int s;
    s = m_w[f][9];
    for (int t = 0; t < 9; t++) if (bits[t]) s += m_w[f][t];
    if (s < 0)   return 8'd0;
    if (s > 255) return 8'd255;
    return s[7:0];
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the write.
  task automatic load_weight(input int addr, input logic [7:0] data);
    w_we   = 1'b1;
    w_addr = AW'(addr);
    w_data = data;
    @(negedge clk);
    w_we = 1'b0;
    if (addr < NF * 10) m_w[addr / 10][addr % 10] = int'($signed(data));
  endtask

  // Accept at cycle 0, taps in cycles 1..9; returns at cycle 11+NF (IDLE).
  task automatic run_window(input logic [8:0] bits, input bit wr_busy,
                            input int wa, input logic [7:0] wd);
    bit  last;
    wr_t e;
    last = (tb_pix == FMAP - 1);
    for (int f = 0; f < NF; f++) begin
      e.addr = 10'(tb_pix);
      e.filt = FW'(f);
      e.data = model(f, bits);
      sb.push_back(e);
    end
    check("bsy_accept", bsy, 0);
    strt = 1'b1;
    for (int c = 1; c <= WR_END + 1; c++) begin
      @(negedge clk);
      strt   = 1'b0;
      din    = (c <= 9) ? bits[c-1] : 1'b0;
      w_we   = wr_busy && (c == 3);
      w_addr = AW'(wa);
      w_data = wd;
      check("bsy", bsy, (c <= WR_END));
      check("fm_we_cycle", fm_we, (c >= 11 && c <= WR_END));
      check("frame_done", frame_done, (c == WR_END + 1) && last);
    end
    w_we   = 1'b0;
    tb_pix = last ? 0 : tb_pix + 1;
  endtask

  // Abort with clr while tap 4 is being sampled.
  task automatic abort_window(input logic [8:0] bits);
    strt = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      strt = 1'b0;
      din  = bits[c-1];
      clr  = (c == 5);
    end
    @(negedge clk);
    clr = 1'b0;
    din = 1'b0;
    check("bsy_after_clr", bsy, 0);
    for (int c = 0; c < 12; c++) begin
      check("fm_we_after_clr", fm_we, 0);
      @(negedge clk);
    end
    tb_pix = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] bits;
    bit         hit_last;
    int         n;
    rst_n = 1'b0; clr = 1'b0; strt = 1'b0; din = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    for (int f = 0; f < NF; f++) for (int t = 0; t < 10; t++) m_w[f][t] = 0;
    repeat (3) @(negedge clk);
    check("rst_bsy", bsy, 0);
    check("rst_fm_we", fm_we, 0);
    check("rst_fm_addr", fm_addr, 0);
    check("rst_fm_filt", fm_filt, 0);
    check("rst_fm_data", fm_data, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1;

    // Reset weights are zero: result is 0 everywhere.
    run_window(9'h1FF, 0, 0, 8'h00);

    for (int f = 0; f < NF; f++) for (int t = 0; t < 9; t++) load_weight(f*10 + t, 8'd1);
    run_window(9'h1FF, 0, 0, 8'h00);

    for (int t = 0; t < 9; t++) load_weight(10 + t, 8'hFB);
    load_weight(19, 8'd3);
    run_window(9'b000000111, 0, 0, 8'h00);

    for (int a = 0; a < NF * 10; a++) load_weight(a, 8'd127);
    load_weight(45, 8'h80);
    run_window(9'h1FF, 0, 0, 8'h00);
    run_window(9'h000, 0, 0, 8'h00);

    for (int a = 0; a < NF * 10; a++) load_weight(a, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) run_window(9'($urandom_range(0, 511)), 0, 0, 8'h00);

    abort_window(9'h1FF);
    run_window(9'h0F5, 0, 0, 8'h00);

    run_window(9'h001, 1, 0, 8'h55);
    load_weight(0, 8'h55);
    run_window(9'h001, 0, 0, 8'h00);

    frames   = 0;
    hit_last = 0;
    n        = 0;
    while (!hit_last && n < FMAP + 2) begin
      hit_last = (tb_pix == FMAP - 1);
      bits = 9'($urandom_range(0, 511));
      run_window(bits, 0, 0, 8'h00);
      n++;
    end
    check("frame_reached", hit_last, 1);
    run_window(9'h1C7, 0, 0, 8'h00);
    check("frame_done_count", frames, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
